// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// fft_pkg: shared types and constants for the FFT datapath blocks.
// Rev 1.0
// ============================================================================
package fft_pkg;

  localparam int DEFAULT_SIZE_DATA = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } cmul_state_t;

  // Issue order of the four partial products; results come back in the same order.
  localparam logic [1:0] K_RR = 2'd0;
  localparam logic [1:0] K_II = 2'd1;
  localparam logic [1:0] K_RI = 2'd2;
  localparam logic [1:0] K_IR = 2'd3;

  function automatic logic a_is_imag(input logic [1:0] k);
    return (k == K_II) || (k == K_IR);
  endfunction

  function automatic logic b_is_imag(input logic [1:0] k);
    return (k == K_II) || (k == K_RI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// cmul_issue_ctrl: issues the four partial products of a complex multiply to
// one shared fixed-latency multiplier and collects the results. Rev 1.0
// ============================================================================
module cmul_issue_ctrl
  import fft_pkg::*;
#(
  parameter int SIZE_DATA = DEFAULT_SIZE_DATA,
  parameter int MUL_LAT   = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_ar,
  input  logic [SIZE_DATA-1:0] i_ai,
  input  logic [SIZE_DATA-1:0] i_br,
  input  logic [SIZE_DATA-1:0] i_bi,
  output logic                 o_mul_valid,
  output logic [SIZE_DATA-1:0] o_mul_a,
  output logic [SIZE_DATA-1:0] o_mul_b,
  input  logic                 i_mul_valid,
  input  logic [SIZE_DATA-1:0] i_mul_result,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_rr,
  output logic [SIZE_DATA-1:0] o_ii,
  output logic [SIZE_DATA-1:0] o_ri,
  output logic [SIZE_DATA-1:0] o_ir,
  output logic                 o_err
);

  localparam int DRAIN_W = 4;

  cmul_state_t          state, state_nxt;
  logic [1:0]           issue_cnt;
  logic [2:0]           res_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [SIZE_DATA-1:0] op_ar, op_ai, op_br, op_bi;
  logic [SIZE_DATA-1:0] p_rr, p_ii, p_ri, p_ir;
  logic                 err;

  logic accept, in_flight, draining, capture, last_capture, stray;

  assign accept       = i_valid && (state == ST_IDLE);
  assign in_flight    = (state == ST_ISSUE) || (state == ST_WAIT);
  // Beats still returning from before a reset must be swallowed without an error.
  assign draining     = (drain_cnt != '0);
  assign capture      = i_mul_valid && !draining && in_flight;
  assign last_capture = capture && (res_cnt == 3'd3);
  assign stray        = i_mul_valid && !draining && !in_flight;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (last_capture)            state_nxt = ST_DONE;
        else if (issue_cnt == K_IR)  state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (last_capture) state_nxt = ST_DONE;
      ST_DONE:  if (i_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_mul_a = '0;
    o_mul_b = '0;
    if (state == ST_ISSUE) begin
      o_mul_a = a_is_imag(issue_cnt) ? op_ai : op_ar;
      o_mul_b = b_is_imag(issue_cnt) ? op_bi : op_br;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      issue_cnt <= '0;
      res_cnt   <= '0;
      drain_cnt <= DRAIN_W'(MUL_LAT);
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (draining) drain_cnt <= drain_cnt - DRAIN_W'(1);
      if (accept) begin
        issue_cnt <= '0;
        res_cnt   <= '0;
      end
      if (state == ST_ISSUE) issue_cnt <= issue_cnt + 2'd1;
      if (capture) res_cnt <= res_cnt + 3'd1;
      if (stray) err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_ar <= '0;
      op_ai <= '0;
      op_br <= '0;
      op_bi <= '0;
      p_rr  <= '0;
      p_ii  <= '0;
      p_ri  <= '0;
      p_ir  <= '0;
    end else begin
      if (accept) begin
        op_ar <= i_ar;
        op_ai <= i_ai;
        op_br <= i_br;
        op_bi <= i_bi;
      end
      if (capture) begin
        case (res_cnt[1:0])
          K_RR: p_rr <= i_mul_result;
          K_II: p_ii <= i_mul_result;
          K_RI: p_ri <= i_mul_result;
          K_IR: p_ir <= i_mul_result;
        endcase
      end
    end
  end

  assign o_ready     = (state == ST_IDLE);
  assign o_valid     = (state == ST_DONE);
  assign o_mul_valid = (state == ST_ISSUE);
  assign o_rr        = p_rr;
  assign o_ii        = p_ii;
  assign o_ri        = p_ri;
  assign o_ir        = p_ir;
  assign o_err       = err;

endmodule
`default_nettype wire

// File: doc/cmul_issue_ctrl.md
CMUL_ISSUE_CTRL -- requirements
Module: cmul_issue_ctrl

Interface
REQ-001 Parameter SIZE_DATA, default 32: width of one IEEE-754 operand or result.
REQ-002 Parameter MUL_LAT, default 3, legal range 1..15: fixed latency of the shared multiplier, in cycles, from issue to result.
REQ-003 Ports, as name  direction  width  meaning:
- i_clk  in  1  single clock; all state changes on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  a complex operand pair is offered.
- o_ready  out  1  the block accepts the offered pair.
- i_ar, i_ai  in  SIZE_DATA  real and imaginary parts of operand A.
- i_br, i_bi  in  SIZE_DATA  real and imaginary parts of operand B.
- o_mul_valid  out  1  an issue to the shared multiplier this cycle.
- o_mul_a, o_mul_b  out  SIZE_DATA  multiplier operands.
- i_mul_valid  in  1  a multiplier result is present; results return in issue order.
- i_mul_result  in  SIZE_DATA  the multiplier product.
- o_valid  out  1  four products are available.
- i_ready  in  1  downstream takes the four products.
- o_rr, o_ii, o_ri, o_ir  out  SIZE_DATA  the products ar*br, ai*bi, ar*bi, ai*br.
- o_err  out  1  sticky flag: a result arrived that was not expected.

Function
REQ-004 The FSM has four states: IDLE, ISSUE, WAIT, DONE.
REQ-005 o_ready = 1 only in IDLE; a pair is accepted when i_valid & o_ready, the four operands are registered and the FSM goes to ISSUE.
REQ-006 ISSUE lasts exactly 4 cycles, indexed by a 2-bit issue counter k = 0..3; o_mul_valid = 1 on each of them.
- Pairs issued per k: 0 -> (ar, br), 1 -> (ai, bi), 2 -> (ar, bi), 3 -> (ai, br).
- o_mul_a and o_mul_b are driven from the registered operands.
REQ-007 After k = 3 the FSM goes to WAIT; o_mul_valid = 0 and o_mul_a/o_mul_b = 0 outside ISSUE.
REQ-008 A 3-bit result counter captures each i_mul_valid beat into rr, ii, ri, ir, in that order, in ISSUE or WAIT.
- Capture while ISSUE is still running (MUL_LAT < 4) is legal and does not disturb issuing.
REQ-009 The capture of the 4th result moves the FSM to DONE; o_valid asserts the next cycle.
- For acceptance at cycle T: issues occur at T+1..T+4, and o_valid = 1 at T+5+MUL_LAT.
REQ-010 In DONE, o_valid and o_rr..o_ir are held stable until i_ready = 1; the FSM then returns to IDLE.
- This costs one bubble: a new pair cannot be accepted in the same cycle as i_ready.
REQ-011 An i_mul_valid beat in IDLE or DONE, or a 5th beat for the same pair, is dropped and sets o_err.
REQ-012 o_err stays set until i_rst.
REQ-013 i_valid outside IDLE is ignored; operand inputs are don't-care when not accepted.
REQ-014 Product registers hold their last value and change only on capture.

Reset
REQ-015 On i_rst the block takes these values on the next edge:
- FSM in IDLE; both counters 0; operand and product registers 0.
- o_valid = 0, o_mul_valid = 0, o_err = 0; o_ready = 1 from the first cycle after reset.
REQ-016 Reset mid-operation abandons the pair: in-flight results are not captured.
REQ-017 For MUL_LAT cycles after i_rst deasserts, i_mul_valid beats are dropped silently (a drain window) and do not set o_err.
- Acceptance of a new pair during the drain window is allowed; result capture begins only after the window ends.

Structure
REQ-018 State enum, SIZE_DATA default and the issue-order constants live in the shared FFT package fft_pkg.
REQ-019 No sub-module: the FSM, counters and registers are flat in cmul_issue_ctrl; the multiplier is external.

Verification
REQ-020 MUL_LAT=3; accept ar=0x3F800000, ai=0x40000000, br=0x40400000, bi=0x40800000 at T; the bench multiplier model is fixed-latency.
- Required: o_mul_valid at T+1..T+4 with the pairs of REQ-006.
- Required: o_valid at T+8 with o_rr=0x40400000, o_ii=0x41000000, o_ri=0x40800000, o_ir=0x40C00000.
REQ-021 Hold i_ready=0 for 5 cycles in DONE.
- Required: o_valid and all four products stable; o_ready=0 throughout; return to IDLE the cycle after i_ready=1.
REQ-022 MUL_LAT=1.
- Required: results captured during ISSUE; o_valid at T+6; no o_err.
REQ-023 Inject i_mul_valid in IDLE.
- Required: o_err=1 the next cycle and stays 1; product registers unchanged.
REQ-024 Assert i_rst at T+3 of an operation with MUL_LAT=3.
- Required: IDLE, all outputs 0; the 2 in-flight beats dropped with o_err=0; the next pair completes correctly.
REQ-025 Back-to-back pairs with i_valid held high.
- Required: acceptance spacing is 6+MUL_LAT cycles; second results match the second operands.
